xbar_output_port: RTL

// - Output-side port unit of the simple mesh XY switch. Takes flits the crossbar steers to one output,

---
 rtl/xbar_output_port_if.sv | 26 ++
 rtl/xbar_output_port.sv | 65 ++++++
 2 files changed

// File: rtl/xbar_output_port_if.sv
// Crossbar-to-link bundle for one switch output port: crossbar write side, link handshake and status.
interface xbar_output_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  full_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  vld_o;
  logic                  rdy_i;
  logic [CW-1:0]         count_o;
  logic                  ovf_o;

  modport master (
    output wr_en_i, data_i, rdy_i,
    input  full_o, data_o, vld_o, count_o, ovf_o
  );

  modport slave (
    input  wr_en_i, data_i, rdy_i,
    output full_o, data_o, vld_o, count_o, ovf_o
  );
endinterface

// File: rtl/xbar_output_port.sv
// Output-side port unit of the mesh XY switch: a first-word-fall-through circular FIFO
// between the crossbar and the neighbour link, with occupancy, full and sticky overflow status.
module xbar_output_port #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  xbar_output_port_if.slave port
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic                  full;
  logic                  vld;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded only from the count register, so full blocks a write
  // even when a read frees a slot on the same edge.
  assign full   = (count == DEPTH_C);
  assign vld    = (count != '0);
  assign wr_acc = port.wr_en_i && !full;
  assign rd_acc = vld && port.rdy_i;

  assign port.full_o  = full;
  assign port.vld_o   = vld;
  assign port.count_o = count;
  assign port.ovf_o   = ovf;
  assign port.data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= port.data_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (port.wr_en_i && full) begin
        ovf <= 1'b1;
      end
    end
  end
endmodule
